// File: rtl/adsr_nco_bank.sv
// adsr_nco_bank: time-multiplexed bank of envelope NCOs.
// One sample_rate pulse sweeps every channel once: the channel's env_time is
// presented to an external step ROM, the returned step is added to the
// channel's phase, and the pre-update scale plus overflow flag are emitted.
//
// Optional build macro: ADSR_NCO_BANK_OVERRUN_EN enables the sticky overrun
// flag (sample_rate seen while a sweep is running). Without it overrun is 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for sample_rate; no ROM address presented
// RUN   | presenting step_addr for channels 0..CHANNELS-1, one per clk
// DRAIN | last ROM read / update in flight, waiting for final env_dv
module adsr_nco_bank #(
  parameter int CHANNELS = 8,
  parameter int NCO_W    = 24,
  parameter int STEP_W   = 19,
  parameter int SCALE_W  = 7,
  parameter int TIME_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_rate,
  input  logic [CHANNELS*TIME_W-1:0]   env_time,
  input  logic [CHANNELS-1:0]          ch_clr,
  input  logic [CHANNELS-1:0]          ch_oneshot,
  output logic [TIME_W-1:0]            step_addr,
  input  logic [STEP_W-1:0]            step_data,
  output logic [SCALE_W-1:0]           env_scale,
  output logic                         env_ovflow,
  output logic [$clog2(CHANNELS)-1:0]  env_ch,
  output logic                         env_dv,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CH_W-1:0]   addr_ch_q;
  logic              upd_v_q;
  logic [CH_W-1:0]   upd_ch_q;

  logic [NCO_W-1:0]  phase_q [CHANNELS];
  logic [CHANNELS-1:0] done_q;

  logic [NCO_W-1:0]  cur_phase;
  logic              cur_done;
  logic [NCO_W:0]    sum;
  logic              carry;
  logic [NCO_W-1:0]  nxt_phase;
  logic              nxt_done;
  logic              nxt_ovf;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: leave DRAIN once the last channel's result is on the outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_rate) state_d = RUN;
      RUN:     if (addr_ch_q == LAST_CH) state_d = DRAIN;
      DRAIN:   if (env_dv && (env_ch == LAST_CH)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Channel being addressed; parks on the last channel until the sweep ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       addr_ch_q <= '0;
    else if (state_q == IDLE)                         addr_ch_q <= '0;
    else if (state_q == RUN && addr_ch_q != LAST_CH)  addr_ch_q <= addr_ch_q + CH_W'(1);
  end

  // ROM address is only driven while a channel is being addressed
  always_comb begin
    step_addr = '0;
    if (state_q == RUN) step_addr = env_time[addr_ch_q*TIME_W +: TIME_W];
  end

  // One-clk delay to line the channel index up with the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_v_q  <= 1'b0;
      upd_ch_q <= '0;
    end else begin
      upd_v_q  <= (state_q == RUN);
      upd_ch_q <= addr_ch_q;
    end
  end

  // Phase update rule; clear wins over carry, a finished one-shot holds
  always_comb begin
    cur_phase = phase_q[upd_ch_q];
    cur_done  = done_q[upd_ch_q];
    sum       = {1'b0, cur_phase} + {{(NCO_W + 1 - STEP_W){1'b0}}, step_data};
    carry     = sum[NCO_W];
    nxt_phase = sum[NCO_W-1:0];
    nxt_done  = 1'b0;
    nxt_ovf   = 1'b0;
    if (ch_clr[upd_ch_q]) begin
      nxt_phase = '0;
    end else if (ch_oneshot[upd_ch_q]) begin
      if (cur_done) begin
        nxt_phase = cur_phase;
        nxt_done  = 1'b1;
      end else if (carry) begin
        nxt_phase = '1;
        nxt_done  = 1'b1;
        nxt_ovf   = 1'b1;
      end
    end else if (carry) begin
      // free-run wraps to zero; done is dropped so a later one-shot restarts
      nxt_phase = '0;
      nxt_ovf   = 1'b1;
    end
  end

  // Per-channel phase/done storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) phase_q[i] <= '0;
      done_q <= '0;
    end else if (upd_v_q) begin
      phase_q[upd_ch_q] <= nxt_phase;
      done_q[upd_ch_q]  <= nxt_done;
    end
  end

  // Registered result; scale/channel hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_dv     <= 1'b0;
      env_ovflow <= 1'b0;
      env_ch     <= '0;
      env_scale  <= '0;
    end else begin
      env_dv     <= upd_v_q;
      env_ovflow <= upd_v_q & nxt_ovf;
      if (upd_v_q) begin
        env_ch    <= upd_ch_q;
        env_scale <= cur_phase[NCO_W-1 -: SCALE_W];
      end
    end
  end

`ifdef ADSR_NCO_BANK_OVERRUN_EN
  logic overrun_q;

  // Sticky: a pulse arriving mid-sweep is dropped, so flag it until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            overrun_q <= 1'b0;
    else if (sample_rate && busy)          overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adsr_nco_bank.sv
// Directed bench for adsr_nco_bank with CHANNELS=4 and a small step ROM model.
module tb_adsr_nco_bank;

  localparam int CHANNELS = 4;
  localparam int NCO_W    = 24;
  localparam int STEP_W   = 19;
  localparam int SCALE_W  = 7;
  localparam int TIME_W   = 7;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       sample_rate;
  logic [CHANNELS*TIME_W-1:0] env_time;
  logic [CHANNELS-1:0]        ch_clr;
  logic [CHANNELS-1:0]        ch_oneshot;
  logic [TIME_W-1:0]          step_addr;
  logic [STEP_W-1:0]          step_data;
  logic [SCALE_W-1:0]         env_scale;
  logic                       env_ovflow;
  logic [1:0]                 env_ch;
  logic                       env_dv;
  logic                       busy;
  logic                       overrun;

  int checks = 0;
  int errors = 0;

  logic [STEP_W-1:0]  rom [128];
  logic [SCALE_W-1:0] got_scale [CHANNELS];
  logic               got_ovf   [CHANNELS];
  int                 got_n;
  int                 dv_n;
  logic               expect_ovr;

  adsr_nco_bank #(
    .CHANNELS(CHANNELS), .NCO_W(NCO_W), .STEP_W(STEP_W),
    .SCALE_W(SCALE_W), .TIME_W(TIME_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_rate(sample_rate), .env_time(env_time),
    .ch_clr(ch_clr), .ch_oneshot(ch_oneshot), .step_addr(step_addr),
    .step_data(step_data), .env_scale(env_scale), .env_ovflow(env_ovflow),
    .env_ch(env_ch), .env_dv(env_dv), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Step ROM: one clock of read latency
  always @(posedge clk) step_data <= rom[step_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where busy drops
  task automatic run_sweep();
    for (int i = 0; i < CHANNELS; i++) begin
      got_scale[i] = 'x;
      got_ovf[i]   = 1'bx;
    end
    got_n = 0;
    sample_rate = 1'b1;
    @(negedge clk);
    sample_rate = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (env_dv) begin
        got_scale[env_ch] = env_scale;
        got_ovf[env_ch]   = env_ovflow;
        got_n++;
      end
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic check_ch(input string tag, input int ch, input logic [6:0] scale, input logic ovf);
    check($sformatf("%s_ch%0d_scale", tag, ch), 32'(got_scale[ch]), 32'(scale));
    check($sformatf("%s_ch%0d_ovflow", tag, ch), 32'(got_ovf[ch]), 32'(ovf));
  endtask

  initial begin
`ifdef ADSR_NCO_BANK_OVERRUN_EN
    expect_ovr = 1'b1;
`else
    expect_ovr = 1'b0;
`endif
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[1] = 19'h40000;
    rom[2] = 19'h40000;
    rom[3] = 19'h40000;
    rom[4] = 19'h00000;

    rst_n       = 1'b0;
    sample_rate = 1'b0;
    env_time    = {7'd4, 7'd3, 7'd2, 7'd1};
    ch_clr      = '0;
    ch_oneshot  = 4'b0010;
    repeat (3) @(negedge clk);

    check("rst_env_scale", 32'(env_scale), 32'h0);
    check("rst_env_ovflow", 32'(env_ovflow), 32'h0);
    check("rst_env_ch", 32'(env_ch), 32'h0);
    check("rst_env_dv", 32'(env_dv), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_step_addr", 32'(step_addr), 32'h0);

    rst_n = 1'b1;
    @(negedge clk);

    // Sweep 1: cycle-by-cycle timing
    sample_rate = 1'b1;
    @(negedge clk);
    sample_rate = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) check($sformatf("t%0d_step_addr", k), 32'(step_addr), 32'(k));
      check($sformatf("t%0d_busy", k), 32'(busy), 32'(k <= 6));
      check($sformatf("t%0d_env_dv", k), 32'(env_dv), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        check($sformatf("t%0d_env_ch", k), 32'(env_ch), 32'(k - 3));
        check($sformatf("t%0d_env_scale", k), 32'(env_scale), 32'h0);
        check($sformatf("t%0d_env_ovflow", k), 32'(env_ovflow), 32'h0);
      end
      if (k < 7) @(negedge clk);
    end

    // Sweeps 2..9 back-to-back
    for (int s = 2; s <= 9; s++) begin
      run_sweep();
      check($sformatf("sweep%0d_dv_count", s), 32'(got_n), 32'd4);
    end

    // Sweep 10: clear ch2, pre-clear phase reported
    ch_clr = 4'b0100;
    run_sweep();
    ch_clr = '0;
    check_ch("s10", 0, 7'h12, 1'b0);
    check_ch("s10", 1, 7'h12, 1'b0);
    check_ch("s10", 2, 7'h12, 1'b0);
    check_ch("s10", 3, 7'h00, 1'b0);

    run_sweep();
    check_ch("s11", 0, 7'h14, 1'b0);
    check_ch("s11", 2, 7'h00, 1'b0);

    for (int s = 12; s <= 63; s++) begin
      run_sweep();
      check($sformatf("sweep%0d_dv_count", s), 32'(got_n), 32'd4);
    end

    run_sweep();
    check_ch("s64", 0, 7'h7E, 1'b1);
    check_ch("s64", 1, 7'h7E, 1'b1);
    check_ch("s64", 2, 7'h6A, 1'b0);
    check_ch("s64", 3, 7'h00, 1'b0);

    run_sweep();
    check_ch("s65", 0, 7'h00, 1'b0);
    check_ch("s65", 1, 7'h7F, 1'b0);

    run_sweep();
    check_ch("s66", 0, 7'h02, 1'b0);
    check_ch("s66", 1, 7'h7F, 1'b0);

    // ch1 back to free-run: held all-ones phase now wraps
    ch_oneshot = 4'b0000;
    run_sweep();
    check_ch("s67", 0, 7'h04, 1'b0);
    check_ch("s67", 1, 7'h7F, 1'b1);
    check_ch("s67", 2, 7'h70, 1'b0);
    check("pre_overlap_overrun", 32'(overrun), 32'h0);

    // Second pulse three cycles into a sweep must be ignored
    sample_rate = 1'b1;
    @(negedge clk);
    sample_rate = 1'b0;
    dv_n = 0;
    for (int c = 1; c <= 12; c++) begin
      if (env_dv) dv_n++;
      sample_rate = (c == 3);
      @(negedge clk);
    end
    sample_rate = 1'b0;
    check("overlap_dv_count", 32'(dv_n), 32'd4);
    check("overlap_busy_end", 32'(busy), 32'h0);
    check("overlap_overrun", 32'(overrun), 32'(expect_ovr));

    // Reset in the middle of a sweep
    sample_rate = 1'b1;
    @(negedge clk);
    sample_rate = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_dv_before", 32'(env_dv), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_env_dv", 32'(env_dv), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_env_scale", 32'(env_scale), 32'h0);
    check("midrst_env_ch", 32'(env_ch), 32'h0);
    check("midrst_env_ovflow", 32'(env_ovflow), 32'h0);
    check("midrst_step_addr", 32'(step_addr), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    dv_n = 0;
    repeat (6) begin
      @(negedge clk);
      if (env_dv || busy) dv_n++;
    end
    check("postrst_quiet", 32'(dv_n), 32'd0);

    run_sweep();
    check("postrst_dv_count", 32'(got_n), 32'd4);
    check_ch("postrst", 0, 7'h00, 1'b0);
    check_ch("postrst", 2, 7'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
